// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined FP multiplier among NUM_REQ requesters: 1 cycle to issue, 1 cycle from result to response; ready drops only when TAG_DEPTH ops are outstanding.
// Define FP_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins) instead of round-robin.
module fp_mult_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 8,
  parameter int ID_W      = 2
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic [NUM_REQ-1:0]    reqValidIn,
  input  logic [NUM_REQ*32-1:0] reqAIn,
  input  logic [NUM_REQ*32-1:0] reqBIn,
  output logic [NUM_REQ-1:0]    reqReadyOut,
  output logic [31:0]           multAOut,
  output logic [31:0]           multBOut,
  output logic                  multValidOut,
  input  logic [31:0]           multDataIn,
  input  logic                  multValidIn,
  output logic [31:0]           respDataOut,
  output logic [NUM_REQ-1:0]    respValidOut,
  output logic                  errorOut
);

  localparam int AW = $clog2(TAG_DEPTH);

  logic                  grant_any;
  logic [ID_W-1:0]       grant_id;
  logic                  xfer;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [31:0]           sel_a;
  logic [31:0]           sel_b;
  logic [ID_W-1:0]       tag_mem [TAG_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;

`ifdef FP_ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (reqValidIn[i]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
  end
`else
  logic            hi_any;
  logic            lo_any;
  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;
  logic [ID_W-1:0] last;

  // Lowest valid index above the last winner, else lowest valid index at or below it.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (reqValidIn[i]) begin
        if (ID_W'(i) > last) begin
          hi_any = 1'b1;
          hi_id  = ID_W'(i);
        end else begin
          lo_any = 1'b1;
          lo_id  = ID_W'(i);
        end
      end
    end
    grant_any = hi_any | lo_any;
    grant_id  = hi_any ? hi_id : lo_id;
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      last <= ID_W'(NUM_REQ - 1);
    end else if (xfer) begin
      last <= grant_id;
    end
  end
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_a = reqAIn[32*i +: 32];
        sel_b = reqBIn[32*i +: 32];
      end
    end
  end

  // Full is judged on the registered count so a same-cycle pop never frees a slot early.
  assign full        = (count == (AW+1)'(TAG_DEPTH));
  assign empty       = (count == '0);
  assign reqReadyOut = (grant_any && !full && rstIn) ? (NUM_REQ'(1) << grant_id) : '0;
  assign xfer        = |(reqValidIn & reqReadyOut);
  assign pop         = multValidIn & ~empty;

  always_ff @(posedge clkIn) begin
    if (xfer) begin
      tag_mem[wr_ptr] <= grant_id;
    end
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (xfer) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({xfer, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      multAOut     <= '0;
      multBOut     <= '0;
      multValidOut <= 1'b0;
      respDataOut  <= '0;
      respValidOut <= '0;
      errorOut     <= 1'b0;
    end else begin
      multValidOut <= xfer;
      if (xfer) begin
        multAOut <= sel_a;
        multBOut <= sel_b;
      end
      respValidOut <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;
      if (pop) respDataOut <= multDataIn;
      // A result with nothing outstanding means the multiplier and tag stream disagree.
      if (multValidIn && empty) errorOut <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboarded bench for fp_mult_arbiter with a fixed-latency multiplier stand-in.
module tb_fp_mult_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 3;
`ifdef FP_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clkIn = 1'b0;
  logic            rstIn;
  logic [NR-1:0]   reqValidIn;
  logic [NR*32-1:0] reqAIn;
  logic [NR*32-1:0] reqBIn;
  logic [NR-1:0]   reqReadyOut;
  logic [31:0]     multAOut;
  logic [31:0]     multBOut;
  logic            multValidOut;
  logic [31:0]     multDataIn;
  logic            multValidIn;
  logic [31:0]     respDataOut;
  logic [NR-1:0]   respValidOut;
  logic            errorOut;

  fp_mult_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(8), .ID_W(2)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .reqValidIn(reqValidIn), .reqAIn(reqAIn), .reqBIn(reqBIn),
    .reqReadyOut(reqReadyOut), .multAOut(multAOut), .multBOut(multBOut),
    .multValidOut(multValidOut), .multDataIn(multDataIn), .multValidIn(multValidIn),
    .respDataOut(respDataOut), .respValidOut(respValidOut), .errorOut(errorOut)
  );

  always #5 clkIn = ~clkIn;

  typedef struct { int id; logic [31:0] d; } resp_t;
  typedef struct { logic [31:0] p; int due; } op_t;

  int    exp_grant[$];
  resp_t exp_resp[$];
  op_t   pend[$];
  int    checks = 0;
  int    errors = 0;
  int    ncyc = 0;
  int    acc_ncyc = 0;
  int    resp_ncyc = 0;
  int    cyc;
  int    got;
  logic  stall;
  logic  spur;
  logic  model_vld;
  logic [31:0] model_dat;

  assign multValidIn = model_vld | spur;
  assign multDataIn  = model_dat;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;
      64'h3FC00000_3FC00000: return 32'h40100000;
      64'hC0000000_40000000: return 32'hC0800000;
      64'h3F800000_3F800000: return 32'h3F800000;
      default:               return 32'hFFFFFFFF;
    endcase
  endfunction

  // In-order multiplier: output LAT cycles after its valid input, held back while stall=1.
  always @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      pend.delete();
      model_vld <= 1'b0;
      model_dat <= '0;
      cyc       <= 0;
    end else begin
      if (multValidOut) pend.push_back('{fmul(multAOut, multBOut), cyc + LAT - 1});
      if (!stall && pend.size() > 0 && pend[0].due <= cyc) begin
        model_vld <= 1'b1;
        model_dat <= pend[0].p;
        pend.pop_front();
      end else begin
        model_vld <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int id;
    resp_t r;
    forever begin
      @(negedge clkIn);
      ncyc++;
      if (rstIn && (reqValidIn & reqReadyOut) != '0) begin
        acc_ncyc = ncyc;
        if (exp_grant.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant actual=%b expected=none", reqReadyOut);
        end else begin
          id = exp_grant.pop_front();
          chk("grant", 32'(reqReadyOut), 32'(1) << id);
        end
      end
      if (respValidOut != '0) begin
        resp_ncyc = ncyc;
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=%b/%h expected=none", respValidOut, respDataOut);
        end else begin
          r = exp_resp.pop_front();
          chk("resp_id", 32'(respValidOut), 32'(1) << r.id);
          chk("resp_data", respDataOut, r.d);
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    reqAIn[32*i +: 32] = a;
    reqBIn[32*i +: 32] = b;
  endtask

  task automatic expect_op(input int id, input logic [31:0] d);
    exp_grant.push_back(id);
    exp_resp.push_back('{id, d});
  endtask

  // Hold mask valid until n accepts or max_cyc cycles; valid stays asserted on return.
  task automatic stream(input logic [NR-1:0] mask, input int n, input int max_cyc, output int acc);
    acc = 0;
    reqValidIn = mask;
    for (int c = 0; c < max_cyc && acc < n; c++) begin
      @(negedge clkIn);
      if ((reqValidIn & reqReadyOut) != '0) acc++;
      @(posedge clkIn);
      #1;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_resp.size() > 0; c++) @(negedge clkIn);
    repeat (4) @(negedge clkIn);
    chk("drain_resp_left", 32'(exp_resp.size()), 0);
    chk("drain_grant_left", 32'(exp_grant.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clkIn); #1;
    rstIn = 1'b0;
    repeat (2) @(negedge clkIn);
    rstIn = 1'b1;
    @(posedge clkIn); #1;
  endtask

  initial begin
    rstIn = 1'b0; reqValidIn = '1; reqAIn = '0; reqBIn = '0; stall = 1'b0; spur = 1'b0;
    #1;
    chk("rst_ready", 32'(reqReadyOut), 0);
    chk("rst_mvalid", 32'(multValidOut), 0);
    chk("rst_multA", multAOut, 0);
    chk("rst_rvalid", 32'(respValidOut), 0);
    chk("rst_rdata", respDataOut, 0);
    chk("rst_error", 32'(errorOut), 0);
    reqValidIn = '0;
    repeat (2) @(negedge clkIn);
    rstIn = 1'b1;
    @(posedge clkIn); #1;

    // Single request from requester 0, with end-to-end latency.
    set_op(0, 32'h40000000, 32'h40400000);
    expect_op(0, 32'h40C00000);
    stream(4'b0001, 1, 20, got);
    reqValidIn = '0;
    chk("single_accepts", 32'(got), 1);
    chk("single_mvalid", 32'(multValidOut), 1);
    chk("single_multA", multAOut, 32'h40000000);
    chk("single_multB", multBOut, 32'h40400000);
    drain();
    chk("single_latency", 32'(resp_ncyc - acc_ncyc), LAT + 2);

    // All four requesters valid continuously.
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 32'h3FC00000, 32'h3FC00000);
    for (int k = 0; k < 8; k++) expect_op(FIXED ? 0 : k % 4, 32'h40100000);
    stream(4'b1111, 8, 40, got);
    reqValidIn = '0;
    chk("all4_accepts", 32'(got), 8);
    drain();

    // Fairness between requesters 1 and 3.
    do_reset();
    set_op(1, 32'h3FC00000, 32'h3FC00000);
    set_op(3, 32'h3F800000, 32'h3F800000);
    for (int k = 0; k < 8; k++) begin
      if (FIXED || k % 2 == 0) expect_op(1, 32'h40100000);
      else                     expect_op(3, 32'h3F800000);
    end
    stream(4'b1010, 8, 40, got);
    reqValidIn = '0;
    chk("fair_accepts", 32'(got), 8);
    drain();

    // Tag FIFO full with results stalled, then release.
    do_reset();
    set_op(0, 32'h40000000, 32'h40400000);
    for (int k = 0; k < 12; k++) expect_op(0, 32'h40C00000);
    stall = 1'b1;
    stream(4'b0001, 100, 20, got);
    chk("full_accepts", 32'(got), 8);
    @(negedge clkIn);
    chk("full_ready_low", 32'(reqReadyOut), 0);
    @(posedge clkIn); #1;
    stall = 1'b0;
    stream(4'b0001, 4, 50, got);
    reqValidIn = '0;
    chk("resume_accepts", 32'(got), 4);
    drain();

    // Spurious result with nothing outstanding.
    @(posedge clkIn); #1;
    spur = 1'b1;
    @(posedge clkIn); #1;
    spur = 1'b0;
    @(negedge clkIn);
    chk("spur_error", 32'(errorOut), 1);
    chk("spur_rvalid", 32'(respValidOut), 0);
    repeat (5) @(negedge clkIn);
    chk("spur_sticky", 32'(errorOut), 1);

    // Reset with five operations outstanding.
    stall = 1'b1;
    for (int k = 0; k < 5; k++) exp_grant.push_back(0);
    stream(4'b0001, 5, 20, got);
    chk("mid_accepts", 32'(got), 5);
    chk("mid_error_held", 32'(errorOut), 1);
    #2;
    rstIn = 1'b0;
    #1;
    chk("mid_rst_mvalid", 32'(multValidOut), 0);
    chk("mid_rst_multA", multAOut, 0);
    chk("mid_rst_multB", multBOut, 0);
    chk("mid_rst_rdata", respDataOut, 0);
    chk("mid_rst_rvalid", 32'(respValidOut), 0);
    chk("mid_rst_error", 32'(errorOut), 0);
    chk("mid_rst_ready", 32'(reqReadyOut), 0);
    reqValidIn = '0;
    stall = 1'b0;
    @(negedge clkIn);
    rstIn = 1'b1;
    @(posedge clkIn); #1;
    set_op(2, 32'hC0000000, 32'h40000000);
    expect_op(2, 32'hC0800000);
    stream(4'b0100, 1, 20, got);
    reqValidIn = '0;
    chk("post_rst_accepts", 32'(got), 1);
    drain();
    repeat (10) @(negedge clkIn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
Shares one pipelined floating_point_multiply instance between NUM_REQ independent requesters. Each cycle it grants at most one requester, registers that requester's operand pair into the multiplier, and records the requester ID in a tag FIFO. When the multiplier reports a product, the arbiter pops the tag and returns the product to the originating requester. It sits between the accelerator's operand sources (e.g. several file_driver pairs on the bench) and the single shared multiplier.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TAG_DEPTH, 8, max outstanding operations (power of 2, >= multiplier latency + 1)
ID_W, 2, width of requester ID (clog2(NUM_REQ))

Ports:
clkIn  input  1  clock
rstIn  input  1  asynchronous active-low reset
reqValidIn  input  NUM_REQ  per-requester operand valid
reqAIn  input  NUM_REQ*32  operand A, requester i at [32*i+31:32*i]
reqBIn  input  NUM_REQ*32  operand B, same packing
reqReadyOut  output  NUM_REQ  one-hot grant / accept
multAOut  output  32  operand A to multiplier dataAIn
multBOut  output  32  operand B to multiplier dataBIn
multValidOut  output  1  to multiplier validIn
multDataIn  input  32  multiplier dataOut
multValidIn  input  1  multiplier validOut
respDataOut  output  32  product returned to requester
respValidOut  output  NUM_REQ  one-hot; bit i marks respDataOut for requester i
errorOut  output  1  sticky protocol error

Behaviour:
- Reset (rstIn=0, async): multAOut/multBOut=0, multValidOut=0, respDataOut=0, respValidOut=0, errorOut=0, tag FIFO emptied, round-robin pointer last=NUM_REQ-1 (requester 0 wins first). reqReadyOut=0 while in reset.
- Grant (combinational): if tag FIFO not full, reqReadyOut = one-hot of first requester with reqValidIn=1, searching from last+1 upward with wrap. If FIFO full, reqReadyOut=0. reqReadyOut depends on reqValidIn; requesters must not make reqValidIn depend on reqReadyOut.
- Transfer: reqValidIn[i] & reqReadyOut[i] at a rising edge. Next cycle: multAOut/multBOut = requester i operands, multValidOut=1, ID i pushed to tag FIFO, last=i. No transfer -> multValidOut=0, operand registers hold value.
- Requester holds operands and valid until accepted; an unaccepted valid is never dropped.
- Full check uses registered count only: a pop in the same cycle does not free a slot for that cycle's grant. Max outstanding = TAG_DEPTH.
- Return: on multValidIn=1, pop head tag t; next cycle respDataOut=multDataIn, respValidOut=one-hot(t) for one cycle. Otherwise respValidOut=0, respDataOut holds.
- No response backpressure: requester must accept a respValidOut pulse.
- Simultaneous push and pop: both occur; count unchanged.
- multValidIn=1 with FIFO empty: no pop, respValidOut stays 0, errorOut set until reset.
- Latency: request accept -> multValidOut 1 cycle; multValidIn -> respValidOut 1 cycle; end-to-end = multiplier latency + 2.
- Ordering: multiplier is in-order, so responses return in global issue order and per requester in request order.
- Reset mid-operation discards all outstanding tags. The multiplier shares rstIn, so no stale results return.

Optional Feature:
FP_ARB_FIXED_PRIORITY_EN: when defined, grant is fixed priority (lowest index wins) and the round-robin pointer is removed. When undefined, round-robin as above. All other behaviour is identical.

Test Plan:
- Single request: req0 A=0x40000000, B=0x40400000 -> one multValidOut pulse with those operands; respValidOut=4'b0001, respDataOut=0x40C00000 at latency+2.
- All four valid continuously after reset, each holding 0x3FC00000 x 0x3FC00000 -> grants 0,1,2,3,0,... one per cycle; every response 0x40100000 tagged in grant order; FIXED_PRIORITY build grants only req0.
- Fairness: req1 and req3 held valid for 8 accepts -> grants alternate 1,3,1,3; each gets 4 responses.
- Full: multiplier model with validOut held low, req0 streaming -> exactly TAG_DEPTH=8 accepts, then reqReadyOut=0. Releasing the results -> issue resumes with no drops or duplicates.
- Spurious result: multValidIn pulse with FIFO empty -> errorOut=1 and sticky, respValidOut stays 0; cleared only by rstIn=0.
- Reset mid-flight: rstIn low with 5 outstanding -> all outputs 0 asynchronously; after release, req2 request 0xC0000000 x 0x40000000 -> 0xC0800000 on respValidOut[2].
